// File: rtl/exec_pkg.sv
// Shared definitions for the EX stage: ALU opcode encodings, the divider
// FSM state encoding and a small opcode helper.
package exec_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLTU = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_DIVU = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return op == ALU_DIVU;
  endfunction

endpackage

// File: rtl/exec_div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load a/b (first step is taken on the load edge)
//   abort         drop the current division immediately
//   a, b          dividend, divisor
//   busy          a division is in progress or its result is pending
//   done          quotient is final this cycle (one-cycle pulse)
//   quotient      result; all-ones when b was zero
//   div0          the last started division had b == 0
module exec_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic            div0
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            div0_q, div0_d;

  // One restoring step: shift the next dividend bit (MSB of quo) into the
  // partial remainder and subtract the divisor if it fits. The remainder is
  // always below the divisor, so XLEN+1 bits are enough and the top bit of
  // the difference is the borrow.
  function automatic logic [2*XLEN-1:0] restore_step(input logic [XLEN-1:0] rem,
                                                     input logic [XLEN-1:0] quo,
                                                     input logic [XLEN-1:0] dvs);
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;
    sh   = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    if (!diff[XLEN]) return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
    else             return {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
  endfunction

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    div0_d = div0_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      dvs_d  = b;
      if (b == '0) begin
        // Divide by zero: no iterations, result is ready next cycle.
        div0_d = 1'b1;
        quo_d  = '1;
        rem_d  = '0;
        cnt_d  = '0;
      end else begin
        div0_d         = 1'b0;
        {rem_d, quo_d} = restore_step('0, a, b);
        cnt_d          = CW'(XLEN - 1);
      end
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        {rem_d, quo_d} = restore_step(rem_q, quo_q, dvs_q);
        cnt_d          = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      div0_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      div0_q <= div0_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == '0);
  assign quotient = quo_q;
  assign div0     = div0_q;

endmodule

// File: rtl/exec_stage_mc.sv
// EX pipeline stage: computes the ALU result and registers the EX/MEM fields.
// Single-cycle ops complete on the next edge; DIVU optionally uses an
// iterative divider and stalls upstream through in_ready.
// Build option: EXEC_HW_DIV_EN
//   defined   - iterative divider + IDLE/DIV/DONE FSM
//   undefined - DIVU is single-cycle with alu_out=0, div0=1, in_ready tied 1
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      ID/EX handshake
//   flush                    kill in-flight or incoming instruction
//   alu_op, op_a, op_b, shamt  operation and operands (shifts act on op_b)
//   rd, rt_data, mem_to_reg, mem_write, no_wb, pc, offset, br  pass-through
//   out_valid, alu_out, zero, sign, div0, xm_*   EX/MEM register outputs
module exec_stage_mc
  import exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN),
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [SHW-1:0]  shamt,
  input  logic [RW-1:0]   rd,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mem_to_reg,
  input  logic            mem_write,
  input  logic            no_wb,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  input  logic [2:0]      br,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic            sign,
  output logic            div0,
  output logic [RW-1:0]   xm_rd,
  output logic [XLEN-1:0] xm_rt,
  output logic            xm_mem_to_reg,
  output logic            xm_mem_write,
  output logic [XLEN-1:0] xm_pc,
  output logic [XLEN-1:0] xm_offset,
  output logic [2:0]      xm_br
);

  logic            accept, is_div, load_single;
  logic [RW-1:0]   rd_eff;
  logic [XLEN-1:0] alu_res;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic            zero_q, zero_d, sign_q, sign_d, div0_q, div0_d;
  logic [RW-1:0]   xm_rd_q, xm_rd_d;
  logic [XLEN-1:0] xm_rt_q, xm_rt_d;
  logic            xm_mem_to_reg_q, xm_mem_to_reg_d;
  logic            xm_mem_write_q, xm_mem_write_d;
  logic [XLEN-1:0] xm_pc_q, xm_pc_d, xm_offset_q, xm_offset_d;
  logic [2:0]      xm_br_q, xm_br_d;

  // Logarithmic shifter: stage k shifts by 2^k when shamt[k] is set.
  function automatic logic [XLEN-1:0] log_shift(input logic [XLEN-1:0] v,
                                                input logic [SHW-1:0]  sh,
                                                input logic            right,
                                                input logic            arith);
    logic [XLEN-1:0] r;
    r = v;
    for (int k = 0; k < SHW; k++) begin
      if (sh[k]) begin
        if (!right)     r = r << (1 << k);
        else if (arith) r = $signed(r) >>> (1 << k);
        else            r = r >> (1 << k);
      end
    end
    return r;
  endfunction

  assign is_div = is_div_op(alu_op);
  assign accept = in_valid & in_ready & ~flush;
  assign rd_eff = no_wb ? '0 : rd;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_MUL:  alu_res = op_a * op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLL:  alu_res = log_shift(op_b, shamt, 1'b0, 1'b0);
      ALU_SRL:  alu_res = log_shift(op_b, shamt, 1'b1, 1'b0);
      ALU_SRA:  alu_res = log_shift(op_b, shamt, 1'b1, 1'b1);
      default:  alu_res = '0;
    endcase
  end

`ifdef EXEC_HW_DIV_EN
  state_e          state_q, state_d;
  logic            div_start, div_abort, div_busy, div_done, div_div0;
  logic            div_result_valid;
  logic [XLEN-1:0] div_quo;

  // Pass-through fields of the DIV instruction, held until its result retires.
  logic [RW-1:0]   hold_rd_q, hold_rd_d;
  logic [XLEN-1:0] hold_rt_q, hold_rt_d, hold_pc_q, hold_pc_d, hold_off_q, hold_off_d;
  logic            hold_mtr_q, hold_mtr_d, hold_mw_q, hold_mw_d;
  logic [2:0]      hold_br_q, hold_br_d;

  exec_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .a        (op_a),
    .b        (op_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .div0     (div_div0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // DONE behaves like IDLE for new work: the quotient is already registered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DIV: begin
        if (flush)          state_d = ST_IDLE;
        else if (div_done)  state_d = ST_DONE;
        else if (!div_busy) state_d = ST_IDLE;
      end
      default: state_d = div_start ? ST_DIV : ST_IDLE;
    endcase
  end

  // div_start is built from in_valid directly rather than accept so it does
  // not loop back through in_ready.
  always_comb begin
    in_ready  = 1'b1;
    div_start = 1'b0;
    div_abort = 1'b0;
    case (state_q)
      ST_DIV: begin
        in_ready  = 1'b0;
        div_abort = flush;
      end
      default: div_start = in_valid & ~flush & is_div;
    endcase
  end

  assign load_single      = accept & ~is_div;
  assign div_result_valid = (state_q == ST_DIV) & div_done & ~flush;

  always_comb begin
    hold_rd_d  = hold_rd_q;
    hold_rt_d  = hold_rt_q;
    hold_mtr_d = hold_mtr_q;
    hold_mw_d  = hold_mw_q;
    hold_pc_d  = hold_pc_q;
    hold_off_d = hold_off_q;
    hold_br_d  = hold_br_q;
    if (div_start) begin
      hold_rd_d  = rd_eff;
      hold_rt_d  = rt_data;
      hold_mtr_d = mem_to_reg;
      hold_mw_d  = mem_write;
      hold_pc_d  = pc;
      hold_off_d = offset;
      hold_br_d  = br;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_rd_q  <= '0;
      hold_rt_q  <= '0;
      hold_mtr_q <= 1'b0;
      hold_mw_q  <= 1'b0;
      hold_pc_q  <= '0;
      hold_off_q <= '0;
      hold_br_q  <= '0;
    end else begin
      hold_rd_q  <= hold_rd_d;
      hold_rt_q  <= hold_rt_d;
      hold_mtr_q <= hold_mtr_d;
      hold_mw_q  <= hold_mw_d;
      hold_pc_q  <= hold_pc_d;
      hold_off_q <= hold_off_d;
      hold_br_q  <= hold_br_d;
    end
  end
`else
  assign in_ready    = 1'b1;
  assign load_single = accept;
`endif

  // Bubbles clear the control fields that could cause side effects downstream;
  // data fields and flags simply hold.
  always_comb begin
    out_valid_d     = 1'b0;
    xm_rd_d         = '0;
    xm_mem_write_d  = 1'b0;
    xm_br_d         = '0;
    alu_out_d       = alu_out_q;
    zero_d          = zero_q;
    sign_d          = sign_q;
    div0_d          = div0_q;
    xm_rt_d         = xm_rt_q;
    xm_mem_to_reg_d = xm_mem_to_reg_q;
    xm_pc_d         = xm_pc_q;
    xm_offset_d     = xm_offset_q;
    if (load_single) begin
      out_valid_d     = 1'b1;
      alu_out_d       = alu_res;
      xm_rd_d         = rd_eff;
      xm_rt_d         = rt_data;
      xm_mem_to_reg_d = mem_to_reg;
      xm_mem_write_d  = mem_write;
      xm_pc_d         = pc;
      xm_offset_d     = offset;
      xm_br_d         = br;
      if (alu_op == ALU_SUB) begin
        zero_d = (op_a == op_b);
        sign_d = (op_a > op_b);
      end
`ifndef EXEC_HW_DIV_EN
      if (is_div) div0_d = 1'b1;
`endif
    end
`ifdef EXEC_HW_DIV_EN
    if (div_result_valid) begin
      out_valid_d     = 1'b1;
      alu_out_d       = div_quo;
      div0_d          = div_div0;
      xm_rd_d         = hold_rd_q;
      xm_rt_d         = hold_rt_q;
      xm_mem_to_reg_d = hold_mtr_q;
      xm_mem_write_d  = hold_mw_q;
      xm_pc_d         = hold_pc_q;
      xm_offset_d     = hold_off_q;
      xm_br_d         = hold_br_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      alu_out_q       <= '0;
      zero_q          <= 1'b0;
      sign_q          <= 1'b0;
      div0_q          <= 1'b0;
      xm_rd_q         <= '0;
      xm_rt_q         <= '0;
      xm_mem_to_reg_q <= 1'b0;
      xm_mem_write_q  <= 1'b0;
      xm_pc_q         <= '0;
      xm_offset_q     <= '0;
      xm_br_q         <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      alu_out_q       <= alu_out_d;
      zero_q          <= zero_d;
      sign_q          <= sign_d;
      div0_q          <= div0_d;
      xm_rd_q         <= xm_rd_d;
      xm_rt_q         <= xm_rt_d;
      xm_mem_to_reg_q <= xm_mem_to_reg_d;
      xm_mem_write_q  <= xm_mem_write_d;
      xm_pc_q         <= xm_pc_d;
      xm_offset_q     <= xm_offset_d;
      xm_br_q         <= xm_br_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_out       = alu_out_q;
  assign zero          = zero_q;
  assign sign          = sign_q;
  assign div0          = div0_q;
  assign xm_rd         = xm_rd_q;
  assign xm_rt         = xm_rt_q;
  assign xm_mem_to_reg = xm_mem_to_reg_q;
  assign xm_mem_write  = xm_mem_write_q;
  assign xm_pc         = xm_pc_q;
  assign xm_offset     = xm_offset_q;
  assign xm_br         = xm_br_q;

endmodule
